operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Register-read / issue stage directly upstream of the ALU.
- Accepts decoded instructions through a valid/ready handshake and reads rs1/rs2 from a local register file.
- Forwards same-cycle writeback data, stalls on scoreboard hazards, and presents a registered instruction_t with rs1_val/rs2_val filled to the ALU.
- Owns the architectural register file; the ALU result path writes back into it via the wb_* port.

Parameters:
- NUM_REGS, 32, number of architectural registers; index width RW = $clog2(NUM_REGS).
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and scoreboard set.
- STALL_CNT_W, 16, width of saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept in_inst this cycle.
- in_inst  in  instruction_t  decoded instruction; uses opcode, rd, rs1, rs2; incoming rs1_val/rs2_val ignored.
- wb_en  in  1  writeback valid (ALU result_out qualified by its inst_out).
- wb_rd  in  RW  writeback destination.
- wb_data  in  32  writeback value.
- out_valid  out  1  out_inst holds a real instruction this cycle.
- out_inst  out  instruction_t  to ALU inst_in; rs1_val/rs2_val populated.
- stall_cycles  out  STALL_CNT_W  count of cycles with in_valid && !in_ready, saturating.

Behaviour:
- Reset (rst=1 at posedge): regfile all zero, pending bits zero, out_valid=0, out_inst='0, stall_cycles=0. in_ready is forced 0 while rst=1. Reset mid-stall discards the held input; upstream re-presents it.
- Operand read, combinational from current regfile:
  - val(rsX) = 0 if ZERO_REG && rsX==0.
  - Otherwise val(rsX) = wb_data if wb_en && wb_rd==rsX (bypass).
  - Otherwise val(rsX) = regfile[rsX].
- Hazard:
  - rsX is blocked if pending[rsX] && !(wb_en && wb_rd==rsX), and is not the zero reg.
  - hazard = in_valid && (blocked(rs1) || blocked(rs2)).
  - in_ready = !rst && !hazard. in_ready is defined even when in_valid=0 and equals 1 absent reset.
- Issue:
  - Fires when in_valid && in_ready.
  - On the next edge: out_valid<=1, out_inst<=in_inst with rs1_val/rs2_val replaced by the bypassed values. Latency is 1 cycle.
  - When no issue: out_valid<=0, out_inst<='0 (opcode 0 = bubble; the ALU yields 0).
  - Downstream always accepts; there is no backpressure from the ALU.
- Scoreboard:
  - On issue with rd!=0 (or any rd if ZERO_REG=0): pending[rd]<=1.
  - On wb_en: pending[wb_rd]<=0.
  - Same register set and cleared in the same cycle: set wins.
- Writeback: wb_en && !(ZERO_REG && wb_rd==0) writes regfile[wb_rd]<=wb_data at the edge. A write to reg 0 with ZERO_REG=1 is dropped entirely.
- Dependent back-to-back ops:
  - Producer issued at edge E.
  - ALU registers its result at E+1; wb_en is asserted in the cycle after E+1.
  - The consumer stalls exactly 1 cycle and then issues with the bypassed value.
- rs1==rs2 is handled with a single pending check; both operands get the same value.
- stall_cycles increments by 1 on each cycle with in_valid && !in_ready && !rst, and holds at all-ones.

Test Plan:
- Reset then regfile read: after rst, issue ADD rd=3 rs1=1 rs2=2 -> next cycle out_valid=1, rs1_val=0, rs2_val=0, pending[3]=1.
- Writeback/read: wb_en rd=5 data=0x1234 at cycle N; issue rs1=5 at N+1 -> out_inst.rs1_val=0x1234. Same-cycle variant (issue at N) -> bypass gives 0x1234.
- RAW stall:
  - Issue ADD rd=4 (rs=0,0), then immediately SUB rs1=4 rs2=4.
  - Required: in_ready=0 for exactly 1 cycle, then SUB issues with rs1_val=rs2_val=wb_data (e.g. 0x0000_0007) when wb_en rd=4 data=7 arrives.
  - stall_cycles=1.
- Zero register:
  - wb_en rd=0 data=0xFFFF_FFFF, then read rs1=0 -> 0.
  - Issue with rd=0 -> no pending set; a following op reading rs1=0 never stalls.
- Set/clear collision: pending[6]=1, wb_en rd=6 in the same cycle another op with rd=6 issues -> pending[6] stays 1; a next reader of 6 stalls until the second writeback.
- Reset mid-stall + saturation:
  - Hold a stalled consumer, assert rst -> out_valid=0, pending clear, stall_cycles=0; after rst deassert the same input issues immediately with value 0.
  - Force STALL_CNT_W=2 and stall 5 cycles -> stall_cycles=3.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: register-read/issue stage with writeback bypass and scoreboard stalls
// Owns the architectural regfile; presents a registered instruction_t to the ALU.
package operand_fetch_pkg;
    typedef struct packed {
        logic [3:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
    } instruction_t;
endpackage

module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int ZERO_REG    = 1,
    parameter int STALL_CNT_W = 16,
    localparam int RW         = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  instruction_t           in_inst,
    input  logic                   wb_en,
    input  logic [RW-1:0]          wb_rd,
    input  logic [31:0]            wb_data,
    output logic                   out_valid,
    output instruction_t           out_inst,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    logic [31:0]            rf_q [NUM_REGS];
    logic [31:0]            rf_d [NUM_REGS];
    logic [NUM_REGS-1:0]    pending_q, pending_d;
    logic                   out_valid_q, out_valid_d;
    instruction_t           out_inst_q, out_inst_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic [RW-1:0]          rs1, rs2, rd;
    logic                   z1, z2, zd, byp1, byp2, blk1, blk2, hazard, fire;
    logic [31:0]            v1, v2;

    function automatic logic is_zero(input logic [RW-1:0] r);
        return (ZERO_REG != 0) && (r == '0);
    endfunction

    always_comb begin
        rs1    = in_inst.rs1[RW-1:0];
        rs2    = in_inst.rs2[RW-1:0];
        rd     = in_inst.rd[RW-1:0];
        z1     = is_zero(rs1);
        z2     = is_zero(rs2);
        zd     = is_zero(rd);
        byp1   = wb_en && (wb_rd == rs1);
        byp2   = wb_en && (wb_rd == rs2);
        v1     = z1 ? 32'd0 : byp1 ? wb_data : rf_q[rs1];
        v2     = z2 ? 32'd0 : byp2 ? wb_data : rf_q[rs2];
        // A writeback landing this cycle resolves the hazard through the bypass
        blk1   = !z1 && pending_q[rs1] && !byp1;
        blk2   = !z2 && pending_q[rs2] && !byp2;
        hazard = in_valid && (blk1 || blk2);
        in_ready = !rst && !hazard;
        fire   = in_valid && in_ready;
        rf_d = rf_q;
        if (wb_en && !is_zero(wb_rd))
            rf_d[wb_rd] = wb_data;
        pending_d = pending_q;
        if (wb_en)
            pending_d[wb_rd] = 1'b0;
        if (fire && !zd)
            pending_d[rd] = 1'b1;
        out_valid_d = fire;
        out_inst_d  = '0;
        if (fire) begin
            out_inst_d         = in_inst;
            out_inst_d.rs1_val = v1;
            out_inst_d.rs2_val = v2;
        end
        stall_d = (in_valid && !in_ready && !rst && stall_q != '1) ? stall_q + STALL_CNT_W'(1) : stall_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q        <= '{default: '0};
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            stall_q     <= '0;
        end else begin
            rf_q        <= rf_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_inst     = out_inst_q;
    assign stall_cycles = stall_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed-vector bench for operand_fetch
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    instruction_t in_inst = '0;
    logic         wb_en = 1'b0;
    logic [4:0]   wb_rd = '0;
    logic [31:0]  wb_data = '0;
    logic         out_valid;
    instruction_t out_inst;
    logic [15:0]  stall_cycles;

    logic         b_rst = 1'b1;
    logic         b_in_valid = 1'b0;
    logic         b_in_ready;
    instruction_t b_in_inst = '0;
    logic         b_wb_en = 1'b0;
    logic [4:0]   b_wb_rd = '0;
    logic [31:0]  b_wb_data = '0;
    logic         b_out_valid;
    instruction_t b_out_inst;
    logic [1:0]   b_stall;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
        .out_inst(out_inst), .stall_cycles(stall_cycles)
    );

    operand_fetch #(.STALL_CNT_W(2)) dut_sat (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst),
        .wb_en(b_wb_en), .wb_rd(b_wb_rd), .wb_data(b_wb_data), .out_valid(b_out_valid),
        .out_inst(b_out_inst), .stall_cycles(b_stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic instruction_t mk(input logic [3:0] o, input logic [4:0] d, input logic [4:0] a,
                                        input logic [4:0] b);
        mk = '{opcode: o, rd: d, rs1: a, rs2: b, rs1_val: 32'hDEADBEEF, rs2_val: 32'hCAFEF00D};
    endfunction

    task automatic issue(input instruction_t i);
        in_valid = 1'b1;
        in_inst  = i;
    endtask

    task automatic wb(input logic e, input logic [4:0] r, input logic [31:0] d);
        wb_en   = e;
        wb_rd   = r;
        wb_data = d;
    endtask

    initial begin
        // reset
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_inst", out_inst.rs1_val | out_inst.rs2_val | 32'(out_inst.opcode), 0);
        chk("rst_stall", stall_cycles, 0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        cyc();

        // first issue after reset reads zeros and sets pending[3]
        issue(mk(4'd1, 5'd3, 5'd1, 5'd2));
        @(negedge clk);
        chk("add_ready", in_ready, 1);
        cyc();
        chk("add_valid", out_valid, 1);
        chk("add_op", out_inst.opcode, 1);
        chk("add_rd", out_inst.rd, 3);
        chk("add_rs1v", out_inst.rs1_val, 0);
        chk("add_rs2v", out_inst.rs2_val, 0);
        issue(mk(4'd2, 5'd0, 5'd3, 5'd0));
        @(negedge clk);
        chk("p3_blocks", in_ready, 0);
        cyc();
        chk("p3_bubble", out_valid, 0);
        wb(1'b1, 5'd3, 32'h55);
        @(negedge clk);
        chk("p3_bypass_ready", in_ready, 1);
        cyc();
        chk("p3_rs1v", out_inst.rs1_val, 32'h55);
        chk("stall_1", stall_cycles, 1);

        // writeback then read, and same-cycle bypass
        in_valid = 1'b0;
        wb(1'b1, 5'd5, 32'h1234);
        cyc();
        wb(1'b0, 5'd0, 0);
        issue(mk(4'd3, 5'd0, 5'd5, 5'd3));
        cyc();
        chk("rd5_rs1v", out_inst.rs1_val, 32'h1234);
        chk("rd3_rs2v", out_inst.rs2_val, 32'h55);
        wb(1'b1, 5'd7, 32'hABCD);
        issue(mk(4'd3, 5'd0, 5'd7, 5'd7));
        cyc();
        chk("byp7_rs1v", out_inst.rs1_val, 32'hABCD);
        chk("byp7_rs2v", out_inst.rs2_val, 32'hABCD);
        wb(1'b0, 5'd0, 0);
        issue(mk(4'd3, 5'd0, 5'd7, 5'd5));
        cyc();
        chk("rf7_rs1v", out_inst.rs1_val, 32'hABCD);
        chk("rf5_rs2v", out_inst.rs2_val, 32'h1234);

        // RAW: consumer stalls exactly one cycle, then takes the bypassed result
        issue(mk(4'd1, 5'd4, 5'd0, 5'd0));
        cyc();
        chk("raw_prod_rd", out_inst.rd, 4);
        issue(mk(4'd4, 5'd0, 5'd4, 5'd4));
        @(negedge clk);
        chk("raw_stall", in_ready, 0);
        cyc();
        chk("raw_bubble_v", out_valid, 0);
        chk("raw_bubble_op", out_inst.opcode, 0);
        wb(1'b1, 5'd4, 32'h7);
        @(negedge clk);
        chk("raw_ready", in_ready, 1);
        cyc();
        chk("raw_valid", out_valid, 1);
        chk("raw_op", out_inst.opcode, 4);
        chk("raw_rs1v", out_inst.rs1_val, 7);
        chk("raw_rs2v", out_inst.rs2_val, 7);
        chk("stall_2", stall_cycles, 2);

        // zero register ignores writes and never becomes pending
        in_valid = 1'b0;
        wb(1'b1, 5'd0, 32'hFFFFFFFF);
        cyc();
        wb(1'b0, 5'd0, 0);
        issue(mk(4'd5, 5'd0, 5'd0, 5'd0));
        cyc();
        chk("zero_rs1v", out_inst.rs1_val, 0);
        chk("zero_rs2v", out_inst.rs2_val, 0);
        issue(mk(4'd6, 5'd0, 5'd0, 5'd0));
        @(negedge clk);
        chk("zero_no_stall", in_ready, 1);
        cyc();
        wb(1'b1, 5'd0, 32'hFFFFFFFF);
        issue(mk(4'd6, 5'd1, 5'd0, 5'd0));
        cyc();
        chk("zero_wb_byp", out_inst.rs1_val, 0);
        wb(1'b0, 5'd0, 0);

        // set/clear collision on reg 6: set wins
        issue(mk(4'd1, 5'd6, 5'd0, 5'd0));
        cyc();
        wb(1'b1, 5'd6, 32'h11);
        issue(mk(4'd1, 5'd6, 5'd0, 5'd0));
        cyc();
        wb(1'b0, 5'd0, 0);
        issue(mk(4'd2, 5'd0, 5'd6, 5'd0));
        @(negedge clk);
        chk("coll_stall", in_ready, 0);
        cyc();
        wb(1'b1, 5'd6, 32'h22);
        @(negedge clk);
        chk("coll_ready", in_ready, 1);
        cyc();
        chk("coll_rs1v", out_inst.rs1_val, 32'h22);
        chk("stall_3", stall_cycles, 3);
        wb(1'b0, 5'd0, 0);

        // reset mid-stall discards state; consumer then issues with zeros
        issue(mk(4'd1, 5'd8, 5'd0, 5'd0));
        cyc();
        issue(mk(4'd2, 5'd0, 5'd8, 5'd3));
        cyc();
        chk("stall_4", stall_cycles, 4);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", in_ready, 0);
        cyc();
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_stall", stall_cycles, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
        cyc();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_rs1v", out_inst.rs1_val, 0);
        chk("post_rst_rs2v", out_inst.rs2_val, 0);
        chk("post_rst_stall", stall_cycles, 0);
        in_valid = 1'b0;

        // 2-bit stall counter saturates at 3
        cyc();
        b_rst = 1'b0;
        b_in_valid = 1'b1;
        b_in_inst = mk(4'd1, 5'd9, 5'd0, 5'd0);
        cyc();
        b_in_inst = mk(4'd2, 5'd0, 5'd9, 5'd0);
        @(negedge clk);
        chk("sat_stall", b_in_ready, 0);
        cyc();
        cyc();
        chk("sat_2", b_stall, 2);
        for (int i = 0; i < 3; i++) cyc();
        chk("sat_3", b_stall, 3);
        b_in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
